ofdm_mapper_cfg: RTL and testbench



---
 rtl/ofdm_cr_pkg.sv | 13 +
 rtl/sym_fifo.sv | 33 +++
 rtl/ofdm_mapper_cfg.sv | 98 +++++++++
 tb/tb_ofdm_mapper_cfg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_cr_pkg.sv
// ofdm_cr_pkg: modulation encodings, amplitudes and Gray level tables shared by the OFDM transmit chain
package ofdm_cr_pkg;
  typedef enum logic [1:0] {MOD_BPSK, MOD_QPSK, MOD_QAM16, MOD_QAM64} mod_e;
  localparam int A1 = 16384;
  localparam int A2 = 11585;
  localparam int U16 = 5181;
  localparam int U64 = 2528;
  localparam int QAM16_LVL [4] = '{-3, -1, 3, 1};
  localparam int QAM64_LVL [8] = '{-7, -5, -1, -3, 7, 5, 1, 3};
  function automatic int bits_per_sym(input mod_e m);
    return m == MOD_BPSK ? 1 : m == MOD_QPSK ? 2 : m == MOD_QAM16 ? 4 : 6;
  endfunction
endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: first-word fall-through symbol FIFO with async reset and simultaneous push/pop
module sym_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  // Pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  // Storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ofdm_mapper_cfg.sv
// ofdm_mapper_cfg: packed-bit stream to BPSK/QPSK/16-QAM/64-QAM symbols with frame-end padding and output FIFO
module ofdm_mapper_cfg
  import ofdm_cr_pkg::*;
#(
  parameter int IN_W = 2,
  parameter int DEPTH = 4,
  parameter int DW = 16
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [1:0]      MOD_SEL,
  input  logic [IN_W-1:0] DAT_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  output logic            ACK_O,
  output logic [2*DW-1:0] DAT_O,
  output logic            CYC_O,
  output logic            STB_O,
  output logic            WE_O,
  input  logic            ACK_I
);
  localparam int BUF_W = IN_W + 5;
  localparam int CW = $clog2(BUF_W + 1);
  logic [BUF_W-1:0] bits, bits_n, kept;
  logic [CW-1:0] cnt, cnt_n, rem, k;
  logic [2*DW-1:0] sym, head;
  mod_e mode;
  logic cyc, full, empty, gen_full, pad, gen, pop;
  function automatic logic [DW-1:0] scale(input int v);
    longint s;
    s = (longint'(v) <<< DW) >>> 16;
    return s[DW-1:0];
  endfunction
  function automatic logic [2*DW-1:0] map_sym(input logic [5:0] b, input mod_e m);
    int i, q;
    case (m)
      MOD_BPSK: begin
        i = b[0] ? A1 : -A1;
        q = 0;
      end
      MOD_QPSK: begin
        i = b[0] ? A2 : -A2;
        q = b[1] ? A2 : -A2;
      end
      MOD_QAM16: begin
        i = QAM16_LVL[{b[0], b[1]}] * U16;
        q = QAM16_LVL[{b[2], b[3]}] * U16;
      end
      default: begin
        i = QAM64_LVL[{b[0], b[1], b[2]}] * U64;
        q = QAM64_LVL[{b[3], b[4], b[5]}] * U64;
      end
    endcase
    return {scale(i), scale(q)};
  endfunction
  assign k = CW'(bits_per_sym(mode));
  assign ACK_O = !RST_I && CYC_I && STB_I && WE_I && (int'(cnt) + IN_W <= BUF_W);
  assign gen_full = cnt >= k;
  assign pad = !CYC_I && cnt != 0 && cnt < k;
  assign gen = !full && (gen_full || pad);
  assign pop = ACK_I && !empty;
  assign sym = map_sym(bits[5:0], mode);
  // Drop the consumed symbol (or the padded residue) and append the accepted beat above what remains
  always_comb begin
    rem = gen ? (gen_full ? cnt - k : '0) : cnt;
    kept = gen ? (gen_full ? bits >> k : '0) : bits;
    bits_n = kept | (ACK_O ? BUF_W'(DAT_I) << rem : '0);
    cnt_n = rem + (ACK_O ? CW'(IN_W) : '0);
  end
  // Bit buffer, per-frame mode latched on the first beat, and output frame flag held until fully drained
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      bits <= '0;
      cnt <= '0;
      mode <= MOD_BPSK;
      cyc <= 1'b0;
    end else begin
      bits <= bits_n;
      cnt <= cnt_n;
      if (ACK_O && !cyc) mode <= mod_e'(MOD_SEL);
      cyc <= ACK_O || (cyc && (CYC_I || cnt != 0 || !empty));
    end
  sym_fifo #(.DEPTH(DEPTH), .W(2 * DW)) u_fifo (
    .clk(CLK_I),
    .rst(RST_I),
    .push(gen),
    .din(sym),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign STB_O = !empty;
  assign WE_O = !empty;
  assign CYC_O = cyc;
  assign DAT_O = empty ? '0 : head;
endmodule

// File: tb/tb_ofdm_mapper_cfg.sv
// tb_ofdm_mapper_cfg: scoreboard bench for the configurable OFDM constellation mapper
module tb_ofdm_mapper_cfg;
  localparam int IN_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mod_sel = '0;
  logic [IN_W-1:0] dat_i = '0;
  logic cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, ack_i = 1'b0;
  logic ack_o, cyc_o, stb_o, we_o;
  logic [31:0] dat_o;
  int checks = 0, passed = 0, beats_acc = 0, ack_mode = 0;
  logic [31:0] exp_q [$];
  logic held = 1'b0;
  logic [31:0] last = '0;

  ofdm_mapper_cfg #(.IN_W(IN_W), .DEPTH(4), .DW(16)) dut (
    .CLK_I(clk), .RST_I(rst), .MOD_SEL(mod_sel), .DAT_I(dat_i),
    .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ACK_O(ack_o),
    .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ACK_I(ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: chop the frame into k-bit groups, zero-pad the tail, Gray-decode each axis to a level
  function automatic void push_model(input int mod, input int nb, input logic [63:0] b);
    int k, m, unit, g, bin;
    int lv [2];
    logic [31:0] li, lq;
    k = mod == 0 ? 1 : mod == 1 ? 2 : mod == 2 ? 4 : 6;
    m = k == 1 ? 1 : k / 2;
    unit = mod == 0 ? 16384 : mod == 1 ? 11585 : mod == 2 ? 5181 : 2528;
    for (int p = 0; p < nb; p += k) begin
      for (int a = 0; a < 2; a++) begin
        g = 0;
        for (int j = 0; j < m; j++) g = (g << 1) | ((p + a * m + j < nb) ? int'(b[p + a * m + j]) : 0);
        bin = g ^ (g >> 1) ^ (g >> 2);
        lv[a] = (2 * bin - ((1 << m) - 1)) * unit;
      end
      if (k == 1) lv[1] = 0;
      li = lv[0];
      lq = lv[1];
      exp_q.push_back({li[15:0], lq[15:0]});
    end
  endfunction

  task automatic drive_frame(input int mod, input int nb, input logic [63:0] b, input bit chg, input bit gaps);
    int t;
    @(posedge clk); #1;
    cyc_i = 1'b1;
    mod_sel = 2'(mod);
    for (int n = 0; n < nb / IN_W; n++) begin
      if (gaps && $urandom % 3 == 0) begin
        stb_i = 1'b0;
        we_i = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      dat_i = b[n * IN_W +: IN_W];
      stb_i = 1'b1;
      we_i = 1'b1;
      #1;
      t = 0;
      while (!ack_o && t < 200) begin @(posedge clk); #2; t++; end
      if (t >= 200) begin
        checks++;
        $display("FAIL ack_timeout: beat %0d never accepted", n);
      end
      @(posedge clk); #1;
      beats_acc++;
      if (chg && n == 0) mod_sel = 2'(mod + 1);
    end
    stb_i = 1'b0;
    we_i = 1'b0;
    cyc_i = 1'b0;
    dat_i = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((cyc_o || exp_q.size() != 0) && t < 1000) begin @(posedge clk); #1; t++; end
    if (t >= 1000) begin
      checks++;
      $display("FAIL idle_timeout: cyc_o=%b pending=%0d expected idle", cyc_o, exp_q.size());
    end
  endtask

  // Downstream accept pattern: 0 always ready, 1 random, 2 stalled
  always @(posedge clk) begin
    #1;
    ack_i = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? 1'($urandom % 2) : 1'b0;
  end

  // Monitor: pop the scoreboard on every output handshake and demand a stable head while stalled
  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        check("hold_stb", stb_o, 1);
        check("hold_dat", dat_o, last);
      end
      if (stb_o) check("we_o", we_o, 1);
      if (stb_o && ack_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_sym: got %h expected none", dat_o);
        end else check("sym", dat_o, exp_q.pop_front());
        held = 1'b0;
      end else begin
        held = stb_o;
        last = dat_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [63:0] rb;
    int mod, nb;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_we", we_o, 0);
    check("rst_cyc", cyc_o, 0);
    check("rst_dat", dat_o, 0);
    rst = 1'b0;
    ack_mode = 0;
    exp_q.push_back(32'h2D41_2D41);
    exp_q.push_back(32'hD2BF_D2BF);
    fork
      drive_frame(1, 4, 64'h3, 0, 0);
      begin
        @(posedge clk); #2;
        t = 0;
        while (!ack_o && t < 50) begin @(posedge clk); #2; t++; end
        @(posedge clk); #2;
        check("lat_early", stb_o, 0);
        @(posedge clk); #2;
        check("lat_stb", stb_o, 1);
      end
    join
    wait_idle();
    exp_q.push_back(32'hC000_0000);
    exp_q.push_back(32'h4000_0000);
    drive_frame(0, 2, 64'h2, 0, 0);
    wait_idle();
    exp_q.push_back(32'h3CB7_EBC3);
    drive_frame(2, 4, 64'h9, 0, 0);
    wait_idle();
    exp_q.push_back(32'h2D41_D2BF);
    exp_q.push_back(32'hD2BF_2D41);
    drive_frame(1, 4, 64'h9, 1, 0);
    wait_idle();
    ack_mode = 2;
    beats_acc = 0;
    rb = {$urandom, $urandom};
    push_model(1, 24, rb);
    fork
      drive_frame(1, 24, rb, 0, 0);
      begin
        repeat (12) @(posedge clk);
        #2;
        check("bp_ack", ack_o, 0);
        check("bp_stb", stb_o, 1);
        check("bp_beats", beats_acc, 7);
        ack_mode = 0;
      end
    join
    wait_idle();
    ack_mode = 2;
    @(posedge clk); #1;
    cyc_i = 1'b1;
    mod_sel = 2'd1;
    stb_i = 1'b1;
    we_i = 1'b1;
    dat_i = 2'b01;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_mid_stb", stb_o, 0);
    check("rst_mid_cyc", cyc_o, 0);
    check("rst_mid_ack", ack_o, 0);
    exp_q.delete();
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_mode = 0;
    exp_q.push_back(32'h09E0_4520);
    exp_q.push_back(32'h09E0_BAE0);
    drive_frame(3, 8, 64'hCB, 0, 0);
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
    #1;
    check("res_drain", stb_o, 0);
    @(posedge clk); #1;
    check("res_cyc", cyc_o, 0);
    wait_idle();
    for (int f = 0; f < 30; f++) begin
      mod = int'($urandom % 4);
      nb = IN_W * int'($urandom_range(1, 8));
      rb = {$urandom, $urandom};
      ack_mode = int'($urandom % 2);
      push_model(mod, nb, rb);
      drive_frame(mod, nb, rb, $urandom % 4 == 0, 1);
      wait_idle();
    end
    check("sb_final", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
